hazard_forward_unit: RTL and testbench

//  Producer side of the 3:1 ALU-operand select path in the 5-stage RISC-V core.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/hazard_forward_unit_fwd_sel.sv | 24 ++
 rtl/hazard_forward_unit.sv | 138 +++++++++++++
 tb/tb_hazard_forward_unit.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the 5-stage RISC-V core: forward selects, result sources, register index width.
package riscv_pkg;

    localparam int unsigned REG_AW = 5;

    // Operand-forward select encodings (11 is never produced)
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Result-source encodings carried with the instruction
    localparam logic [1:0] RESULT_ALU  = 2'b00;
    localparam logic [1:0] RESULT_LOAD = 2'b01;
    localparam logic [1:0] RESULT_PC4  = 2'b10;

endpackage

// File: rtl/hazard_forward_unit_fwd_sel.sv
// Forward select for one ALU operand: the M-stage producer beats the W-stage one, x0 is never forwarded.
module fwd_sel #(
    parameter int unsigned AW = riscv_pkg::REG_AW
) (
    input  logic [AW-1:0] i_rs_e,
    input  logic [AW-1:0] i_rd_m,
    input  logic          i_wr_m,
    input  logic [AW-1:0] i_rd_w,
    input  logic          i_wr_w,
    output logic [1:0]    o_sel_c
);
    import riscv_pkg::*;

    // Priority select: M result, then W result, else register file
    always_comb begin
        o_sel_c = FWD_RF;
        if (i_wr_m && (i_rd_m != '0) && (i_rd_m == i_rs_e)) begin
            o_sel_c = FWD_MEM;
        end else if (i_wr_w && (i_rd_w != '0) && (i_rd_w == i_rs_e)) begin
            o_sel_c = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding control for the 5-stage core: shadows rd/regwrite/load for E, M, W,
// drives the operand forward selects and the stall/flush controls.
// Optional perf counters are built when HAZARD_PERF_EN is defined; otherwise tied to 0.
module hazard_forward_unit #(
    parameter int unsigned REG_AW = riscv_pkg::REG_AW,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_d,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rd_d,
    input  logic              regwrite_d,
    input  logic [1:0]        resultsrc_d,
    input  logic              pcsrc_e,
    output logic [1:0]        forward_a_e,
    output logic [1:0]        forward_b_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              flush_e,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);
    import riscv_pkg::*;

    // E stage shadow
    logic [REG_AW-1:0] r_rs1_e;
    logic [REG_AW-1:0] r_rs2_e;
    logic [REG_AW-1:0] r_rd_e;
    logic              r_wr_e;
    logic              r_ld_e;
    // M and W stage shadows
    logic [REG_AW-1:0] r_rd_m;
    logic              r_wr_m;
    logic [REG_AW-1:0] r_rd_w;
    logic              r_wr_w;

    logic w_pcsrc;
    logic w_lwstall;
    logic w_stall;
    logic w_bubble_e;

    // Branch redirect is masked while in reset so every control output reads 0
    assign w_pcsrc = pcsrc_e & rst_n;

    // Load in E whose destination feeds the real instruction waiting in D
    assign w_lwstall = r_ld_e && (r_rd_e != '0) && valid_d &&
                       ((r_rd_e == rs1_d) || (r_rd_e == rs2_d));

    // A taken branch squashes the dependent instruction, so it overrides the stall
    assign w_stall    = w_lwstall & ~w_pcsrc;
    assign w_bubble_e = w_lwstall | w_pcsrc;

    assign stall_f = w_stall;
    assign stall_d = w_stall;
    assign flush_d = w_pcsrc;
    assign flush_e = w_bubble_e;

    // Shadow pipeline: W<=M, M<=E, E<=D or a bubble on flush/stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs1_e <= '0;
            r_rs2_e <= '0;
            r_rd_e  <= '0;
            r_wr_e  <= 1'b0;
            r_ld_e  <= 1'b0;
            r_rd_m  <= '0;
            r_wr_m  <= 1'b0;
            r_rd_w  <= '0;
            r_wr_w  <= 1'b0;
        end else begin
            r_rd_w <= r_rd_m;
            r_wr_w <= r_wr_m;
            r_rd_m <= r_rd_e;
            r_wr_m <= r_wr_e;
            if (w_bubble_e) begin
                r_rs1_e <= '0;
                r_rs2_e <= '0;
                r_rd_e  <= '0;
                r_wr_e  <= 1'b0;
                r_ld_e  <= 1'b0;
            end else begin
                r_rs1_e <= rs1_d;
                r_rs2_e <= rs2_d;
                r_rd_e  <= rd_d;
                r_wr_e  <= regwrite_d & valid_d;
                r_ld_e  <= (resultsrc_d == RESULT_LOAD);
            end
        end
    end

    fwd_sel #(.AW(REG_AW)) u_fwd_a (
        .i_rs_e  (r_rs1_e),
        .i_rd_m  (r_rd_m),
        .i_wr_m  (r_wr_m),
        .i_rd_w  (r_rd_w),
        .i_wr_w  (r_wr_w),
        .o_sel_c (forward_a_e)
    );

    fwd_sel #(.AW(REG_AW)) u_fwd_b (
        .i_rs_e  (r_rs2_e),
        .i_rd_m  (r_rd_m),
        .i_wr_m  (r_wr_m),
        .i_rd_w  (r_rd_w),
        .i_wr_w  (r_wr_w),
        .o_sel_c (forward_b_e)
    );

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Count effective load-use stall cycles and taken-branch flush cycles (wrapping)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_pcsrc) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: directed scenarios plus randomized traffic
// checked against an instruction-history model of the pipeline.
module tb_hazard_forward_unit;

    logic        clk;
    logic        rst_n;
    logic        valid_d;
    logic [4:0]  rs1_d;
    logic [4:0]  rs2_d;
    logic [4:0]  rd_d;
    logic        regwrite_d;
    logic [1:0]  resultsrc_d;
    logic        pcsrc_e;
    logic [1:0]  forward_a_e;
    logic [1:0]  forward_b_e;
    logic        stall_f;
    logic        stall_d;
    logic        flush_d;
    logic        flush_e;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    int checks = 0;
    int errors = 0;

    hazard_forward_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_d     (valid_d),
        .rs1_d       (rs1_d),
        .rs2_d       (rs2_d),
        .rd_d        (rd_d),
        .regwrite_d  (regwrite_d),
        .resultsrc_d (resultsrc_d),
        .pcsrc_e     (pcsrc_e),
        .forward_a_e (forward_a_e),
        .forward_b_e (forward_b_e),
        .stall_f     (stall_f),
        .stall_d     (stall_d),
        .flush_d     (flush_d),
        .flush_e     (flush_e),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the instructions currently occupying E (0), M (1) and W (2)
    typedef struct {
        bit       wr;
        bit       ld;
        bit [4:0] rd;
        bit [4:0] rs1;
        bit [4:0] rs2;
    } ins_t;

    ins_t        hist [3];
    int unsigned m_stall;
    int unsigned m_flush;

    function automatic ins_t bubble();
        ins_t b;
        b.wr = 0; b.ld = 0; b.rd = 0; b.rs1 = 0; b.rs2 = 0;
        return b;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) hist[i] = bubble();
        m_stall = 0;
        m_flush = 0;
    endfunction

    // Which older instruction (if any) supplies source register rs for the one in E
    function automatic bit [1:0] model_fwd(bit [4:0] rs);
        if (rs == 0) return 2'b00;
        if (hist[1].wr && hist[1].rd == rs) return 2'b10;
        if (hist[2].wr && hist[2].rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit model_lw();
        return hist[0].ld && hist[0].rd != 0 && valid_d &&
               (hist[0].rd == rs1_d || hist[0].rd == rs2_d);
    endfunction

    task automatic drive(bit v, bit [4:0] rd, bit [4:0] rs1, bit [4:0] rs2, bit wr, bit [1:0] rsrc, bit pc);
        valid_d = v; rd_d = rd; rs1_d = rs1; rs2_d = rs2;
        regwrite_d = wr; resultsrc_d = rsrc; pcsrc_e = pc;
        #1;
    endtask

    // Advance one clock; model retires W and accepts D into E unless a bubble is due
    task automatic tick();
        bit   lw;
        bit   pc;
        ins_t n;
        lw = model_lw();
        pc = pcsrc_e;
        n.wr = regwrite_d && valid_d; n.ld = (resultsrc_d == 2'b01);
        n.rd = rd_d; n.rs1 = rs1_d; n.rs2 = rs2_d;
        @(posedge clk);
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = (lw || pc) ? bubble() : n;
        if (lw && !pc) m_stall++;
        if (pc) m_flush++;
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        drive(0, 0, 0, 0, 0, 2'b00, 0);
        rst_n = 1'b1;
        #1;
        checks += 4;
        if (forward_a_e !== 2'b00 || forward_b_e !== 2'b00) begin
            errors++; $display("FAIL reset_fwd: got a=%b b=%b want 00 00", forward_a_e, forward_b_e);
        end
        if ({stall_f, stall_d, flush_d, flush_e} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctl: got %b want 0000", {stall_f, stall_d, flush_d, flush_e});
        end
        if (stall_cnt !== 32'd0) begin
            errors++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
        end
        if (flush_cnt !== 32'd0) begin
            errors++; $display("FAIL reset_flush_cnt: got %0d want 0", flush_cnt);
        end

        // Build a pending x5 writer in M, then reset mid-run with a branch asserted
        drive(1, 5, 1, 2, 1, 2'b00, 0); tick();
        drive(1, 6, 5, 1, 1, 2'b00, 0); tick();
        checks++;
        if (forward_a_e !== 2'b10) begin
            errors++; $display("FAIL reset_pre_fwd_a: got %b want 10", forward_a_e);
        end
        drive(1, 7, 6, 6, 1, 2'b00, 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({forward_a_e, forward_b_e, stall_f, stall_d, flush_d, flush_e} !== 8'd0) begin
            errors++; $display("FAIL reset_mid_outputs: got %b want 00000000",
                {forward_a_e, forward_b_e, stall_f, stall_d, flush_d, flush_e});
        end
        rst_n = 1'b1;
        drive(1, 8, 5, 6, 1, 2'b00, 0); tick();
        checks++;
        if (forward_a_e !== 2'b00 || forward_b_e !== 2'b00) begin
            errors++; $display("FAIL reset_post_fwd: got a=%b b=%b want 00 00", forward_a_e, forward_b_e);
        end
    endtask

    task automatic test_back_to_back();
        drive(1, 5, 1, 2, 1, 2'b00, 0); tick();   // add x5,x1,x2
        drive(1, 6, 5, 1, 1, 2'b00, 0); tick();   // add x6,x5,x1
        checks += 2;
        if (forward_a_e !== 2'b10) begin
            errors++; $display("FAIL b2b_fwd_a: got %b want 10", forward_a_e);
        end
        if (forward_b_e !== 2'b00) begin
            errors++; $display("FAIL b2b_fwd_b: got %b want 00", forward_b_e);
        end
    endtask

    task automatic test_wb_forward();
        drive(1, 5, 1, 2, 1, 2'b00, 0); tick();   // add x5
        drive(0, 0, 0, 0, 0, 2'b00, 0); tick();   // nop
        drive(1, 7, 1, 5, 1, 2'b00, 0); tick();   // sub x7,x1,x5
        checks += 2;
        if (forward_b_e !== 2'b01) begin
            errors++; $display("FAIL wb_fwd_b: got %b want 01", forward_b_e);
        end
        if (forward_a_e !== 2'b00) begin
            errors++; $display("FAIL wb_fwd_a: got %b want 00", forward_a_e);
        end
        drive(1, 0, 1, 2, 1, 2'b00, 0); tick();   // add x0 (writes discarded)
        drive(0, 0, 0, 0, 0, 2'b00, 0); tick();
        drive(1, 7, 1, 0, 1, 2'b00, 0); tick();   // sub x7,x1,x0
        checks++;
        if (forward_b_e !== 2'b00) begin
            errors++; $display("FAIL wb_x0_fwd_b: got %b want 00", forward_b_e);
        end
    endtask

    task automatic test_load_use();
        drive(1, 5, 1, 0, 1, 2'b01, 0); tick();   // lw x5,0(x1)
        drive(1, 6, 5, 5, 1, 2'b00, 0);           // add x6,x5,x5
        checks++;
        if ({stall_f, stall_d, flush_d, flush_e} !== 4'b1101) begin
            errors++; $display("FAIL lu_stall: got f/d/fd/fe=%b want 1101", {stall_f, stall_d, flush_d, flush_e});
        end
        tick();                                   // D held, bubble into E
        checks++;
        if ({stall_f, stall_d, flush_e} !== 3'b000) begin
            errors++; $display("FAIL lu_one_cycle: got f/d/fe=%b want 000", {stall_f, stall_d, flush_e});
        end
        tick();
        checks += 2;
        if (forward_a_e !== 2'b01) begin
            errors++; $display("FAIL lu_fwd_a: got %b want 01", forward_a_e);
        end
        if (forward_b_e !== 2'b01) begin
            errors++; $display("FAIL lu_fwd_b: got %b want 01", forward_b_e);
        end
    endtask

    task automatic test_branch_over_stall();
        drive(1, 5, 1, 0, 1, 2'b01, 0); tick();   // lw x5
        drive(1, 6, 5, 1, 1, 2'b00, 1);           // dependent, branch taken
        checks++;
        if ({stall_f, stall_d, flush_d, flush_e} !== 4'b0011) begin
            errors++; $display("FAIL br_over_stall: got f/d/fd/fe=%b want 0011", {stall_f, stall_d, flush_d, flush_e});
        end
        tick();
        drive(0, 0, 0, 0, 0, 2'b00, 0);
    endtask

    task automatic test_counters();
        rst_n = 1'b0;
        model_reset();
        #1;
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 2'b00, 0); tick();
        for (int k = 0; k < 3; k++) begin
            drive(1, 5, 1, 0, 1, 2'b01, 0); tick();
            drive(1, 6, 5, 2, 1, 2'b00, 0); tick(); tick();
        end
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 0, 0, 0, 2'b00, 1); tick();
        end
        drive(0, 0, 0, 0, 0, 2'b00, 0);
        checks += 2;
`ifdef HAZARD_PERF_EN
        if (stall_cnt !== 32'd3) begin
            errors++; $display("FAIL cnt_stall: got %0d want 3", stall_cnt);
        end
        if (flush_cnt !== 32'd2) begin
            errors++; $display("FAIL cnt_flush: got %0d want 2", flush_cnt);
        end
`else
        if (stall_cnt !== 32'd0) begin
            errors++; $display("FAIL cnt_stall_tied: got %0d want 0", stall_cnt);
        end
        if (flush_cnt !== 32'd0) begin
            errors++; $display("FAIL cnt_flush_tied: got %0d want 0", flush_cnt);
        end
`endif
    endtask

    task automatic test_random();
        bit          hold;
        bit [1:0]    ea;
        bit [1:0]    eb;
        bit          lw;
        bit          pc;
        bit [31:0]   es;
        bit [31:0]   ef;
        hold = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                rst_n = 1'b1;
                hold = 0;
            end
            pc = ($urandom_range(0, 99) < 15);
            if (hold) begin
                pcsrc_e = pc;
                #1;
            end else begin
                drive(($urandom_range(0, 9) < 8), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), pc);
            end
            ea = model_fwd(hist[0].rs1);
            eb = model_fwd(hist[0].rs2);
            lw = model_lw();
`ifdef HAZARD_PERF_EN
            es = m_stall;
            ef = m_flush;
`else
            es = 0;
            ef = 0;
`endif
            checks += 5;
            if (forward_a_e !== ea) begin
                errors++; $display("FAIL rand_fwd_a cyc %0d: got %b want %b", cyc, forward_a_e, ea);
            end
            if (forward_b_e !== eb) begin
                errors++; $display("FAIL rand_fwd_b cyc %0d: got %b want %b", cyc, forward_b_e, eb);
            end
            if ({stall_f, stall_d} !== {2{lw && !pc}}) begin
                errors++; $display("FAIL rand_stall cyc %0d: got %b want %b", cyc, {stall_f, stall_d}, {2{lw && !pc}});
            end
            if ({flush_d, flush_e} !== {pc, lw || pc}) begin
                errors++; $display("FAIL rand_flush cyc %0d: got %b want %b", cyc, {flush_d, flush_e}, {pc, lw || pc});
            end
            if (stall_cnt !== es || flush_cnt !== ef) begin
                errors++; $display("FAIL rand_cnt cyc %0d: got %0d/%0d want %0d/%0d", cyc, stall_cnt, flush_cnt, es, ef);
            end
            hold = lw && !pc;
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        valid_d = 0; rs1_d = 0; rs2_d = 0; rd_d = 0;
        regwrite_d = 0; resultsrc_d = 0; pcsrc_e = 0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_back_to_back();
        test_wb_forward();
        test_load_use();
        test_branch_over_stall();
        test_counters();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
